// File: rtl/mul_div_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit and its neighbours
// (instruction decoder, single-cycle ALU).
package mul_div_seq_pkg;

    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SMUL = 3'b101;
    localparam logic [2:0] OP_UMUL = 3'b110;
    localparam logic [2:0] OP_DIV  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ITER   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/mul_div_seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract
// the divisor if it fits, and report the resulting quotient bit.
module mul_div_seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_out
);

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // When the subtraction succeeds the difference is below the divisor, so the
    // low WIDTH bits of the modular subtraction are exact.
    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = trial[WIDTH-1:0] - divisor;
        q_out   = (trial >= {1'b0, divisor});
        rem_out = q_out ? diff : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative multiply/divide unit: one product or quotient bit per cycle,
// start/busy/done handshake, results held until the next completion.
//
// state    | meaning
// S_IDLE   | waiting for start with op[2]=1; done pulses here after FINISH
// S_ITER   | WIDTH shift-add or restoring-divide iterations
// S_FINISH | sign fix-up, result/flag register write
module mul_div_seq
    import mul_div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] long_result,
    output logic [3:0]       flags
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   long_q, long_d;
    logic [3:0]         flags_q, flags_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem;
    logic               div_q;
    logic [2*WIDTH-1:0] prod;
    logic               is_smul;
    logic [WIDTH-1:0]   a_in, b_in;
    logic               flag_n, flag_z;

    mul_div_seq_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (acc_hi_q),
        .bit_in  (acc_lo_q[WIDTH-1]),
        .divisor (opb_q),
        .rem_out (div_rem),
        .q_out   (div_q)
    );

    // Multiplier sits in acc_lo and shifts out LSB-first while the product fills in from the top.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});

    // SMUL works on magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    assign is_smul = (op == OP_SMUL);
    assign a_in    = (is_smul && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_in    = (is_smul && b[WIDTH-1]) ? (~b + 1'b1) : b;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        long_d   = long_q;
        flags_d  = flags_q;
        prod     = {acc_hi_q, acc_lo_q};
        flag_n   = 1'b0;
        flag_z   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && op[2]) begin
                    op_d     = op;
                    opa_d    = a_in;
                    opb_d    = b_in;
                    neg_d    = is_smul && (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_hi_d = '0;
                    acc_lo_d = (op == OP_DIV) ? a : b_in;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_ITER;
                end
            end
            S_ITER: begin
                if (op_q == OP_DIV) begin
                    acc_hi_d = div_rem;
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_q};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (neg_q) begin
                    prod = ~prod + 1'b1;
                end
                case (op_q)
                    OP_SMUL, OP_UMUL: begin
                        result_d = prod[WIDTH-1:0];
                        long_d   = prod[2*WIDTH-1:WIDTH];
                        flag_n   = prod[2*WIDTH-1];
                        flag_z   = (prod == '0);
                    end
                    OP_DIV: begin
                        // Divide by zero reports quotient 0 and the untouched dividend.
                        result_d = (opb_q == '0) ? '0 : acc_lo_q;
                        long_d   = (opb_q == '0) ? opa_q : acc_hi_q;
                        flag_n   = result_d[WIDTH-1];
                        flag_z   = (result_d == '0);
                    end
                    default: begin
                        result_d = prod[WIDTH-1:0];
                        long_d   = '0;
                        flag_n   = prod[WIDTH-1];
                        flag_z   = (prod[WIDTH-1:0] == '0);
                    end
                endcase
                flags_d = {flag_n, flag_z, 2'b00};
                cnt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            long_q   <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            long_q   <= long_d;
            flags_q  <= flags_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign long_result = long_q;
    assign flags       = flags_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: arithmetic reference model checked every cycle, plus
// directed cases with literal expectations and a randomized request stream.
module tb_mul_div_seq;
    import mul_div_seq_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] result, long_result;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    mul_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .long_result (long_result),
        .flags       (flags)
    );

    int n_checks = 0;
    int n_fail = 0;
    int done_seen = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the unit must report for one operation, from plain arithmetic.
    function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] r, output logic [W-1:0] l,
                                   output logic [3:0] f);
        logic [63:0] p;
        longint sx, sy;
        r = '0;
        l = '0;
        p = '0;
        case (o)
            OP_MUL: begin
                p = {32'd0, x} * {32'd0, y};
                r = p[31:0];
            end
            OP_SMUL: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p = sx * sy;
                r = p[31:0];
                l = p[63:32];
            end
            OP_UMUL: begin
                p = {32'd0, x} * {32'd0, y};
                r = p[31:0];
                l = p[63:32];
            end
            default: begin
                if (y == 0) begin
                    r = 0;
                    l = x;
                end else begin
                    r = x / y;
                    l = x % y;
                end
            end
        endcase
        if (o == OP_SMUL || o == OP_UMUL)
            f = {l[W-1], ({l, r} == 64'd0), 2'b00};
        else
            f = {r[W-1], (r == 0), 2'b00};
    endfunction

    // Cycle-level expectation: an accepted request completes WIDTH+1 edges later.
    int           m_left = 0;
    logic         m_busy = 0, m_done = 0;
    logic [W-1:0] m_res = '0, m_long = '0, p_res = '0, p_long = '0;
    logic [3:0]   m_flags = '0, p_flags = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_busy = 0; m_done = 0;
            m_res = '0; m_long = '0; m_flags = '0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_busy = 0;
                    m_res = p_res; m_long = p_long; m_flags = p_flags;
                end
            end else if (start && op[2]) begin
                ref_op(op, a, b, p_res, p_long, p_flags);
                m_left = W + 1;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("result", {32'd0, result}, {32'd0, m_res});
            chk("long_result", {32'd0, long_result}, {32'd0, m_long});
            chk("flags", {60'd0, flags}, {60'd0, m_flags});
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic launch(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    endtask

    // Called at the sample point of cycle k0 after accept; returns cycle index of done.
    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (done !== 1'b1 && k < 80) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_chk(input string name, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] er, input logic [W-1:0] el,
                           input logic [3:0] ef);
        int k;
        launch(o, x, y);
        wait_done(1, k);
        chk({name, "_latency"}, 64'(k), 64'd34);
        chk({name, "_result"}, {32'd0, result}, {32'd0, er});
        chk({name, "_long"}, {32'd0, long_result}, {32'd0, el});
        chk({name, "_flags"}, {60'd0, flags}, {60'd0, ef});
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k, seen0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_long", {32'd0, long_result}, 64'd0);
        chk("reset_flags", {60'd0, flags}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_chk("mul_7x6", OP_MUL, 32'd7, 32'd6, 32'h0000_002A, 32'd0, 4'b0000);
        @(negedge clk);
        run_chk("smul_m3x5", OP_SMUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 4'b1000);
        run_chk("smul_minxmin", OP_SMUL, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h4000_0000, 4'b0000);
        run_chk("umul_max", OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1000);
        run_chk("umul_zero", OP_UMUL, 32'd0, 32'd123, 32'd0, 32'd0, 4'b0100);
        run_chk("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000);
        run_chk("div_by_zero", OP_DIV, 32'd5, 32'd0, 32'd0, 32'd5, 4'b0100);
        @(negedge clk);

        // start held high with new operands during busy must not queue a second op
        seen0 = done_seen;
        launch(OP_MUL, 32'd3, 32'd4);
        repeat (20) begin
            start = 1'b1; op = OP_DIV; a = $urandom; b = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(21, k);
        chk("held_latency", 64'(k), 64'd34);
        chk("held_result", {32'd0, result}, 64'd12);
        repeat (40) @(negedge clk);
        chk("held_single_done", 64'(done_seen - seen0), 64'd1);

        // invalid op in IDLE
        seen0 = done_seen;
        start = 1'b1; op = 3'b010; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("invalid_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("invalid_no_done", 64'(done_seen - seen0), 64'd0);

        // reset in the middle of a divide
        launch(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        chk("abort_long", {32'd0, long_result}, 64'd0);
        seen0 = done_seen;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_seen - seen0), 64'd0);
        run_chk("mul_after_abort", OP_MUL, 32'd7, 32'd6, 32'h0000_002A, 32'd0, 4'b0000);

        // randomized request stream, including invalid ops and back-to-back starts
        for (int i = 0; i < 6000; i++) begin
            start = ($urandom_range(0, 9) < 3);
            op = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 60 && busy === 1'b1; i++) @(negedge clk);
        @(negedge clk);
        chk("final_idle", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_seq.md
Name: mul_div_seq

Overview:
- Iterative multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Takes over the MUL/SMUL/UMUL/DIV encodings of ALUControl (3'b100..3'b111) so the long combinational multiplier/divider leaves the critical path.
- Handshake: start/busy/done. The control unit stalls the pipeline while busy=1.
- Results are written back through the same Result/Long writeback path as the ALU.

Parameters:
- WIDTH, 32, operand width; result and long_result are WIDTH each, and the product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  ALUControl encoding: 100 MUL, 101 SMUL, 110 UMUL, 111 DIV; 0xx is invalid.
- a  input  WIDTH  operand A (multiplicand / dividend).
- b  input  WIDTH  operand B (multiplier / divisor).
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse when results become valid.
- result  output  WIDTH  low product or quotient.
- long_result  output  WIDTH  high product (SMUL/UMUL), remainder (DIV), 0 (MUL).
- flags  output  4  {N,Z,C,V}; C and V are always 0.

Behaviour:
- Reset (synchronous):
  - state=IDLE.
  - busy=0, done=0.
  - result=0, long_result=0, flags=0.
  - Internal accumulators and counter = 0.
  - A reset mid-operation aborts with no done pulse.
- State machine IDLE -> ITER -> FINISH -> IDLE:
  - IDLE: if start=1 and op[2]=1, latch op, a, b into internal registers (later changes on a/b/op are ignored), counter=0, go to ITER.
  - IDLE: start with op[2]=0 is ignored; the unit stays in IDLE.
  - ITER: exactly WIDTH cycles, one bit per cycle; counter increments; leave when counter==WIDTH-1.
  - FINISH: one cycle for sign fix-up and register writes; then IDLE with done=1 for that single cycle.
- Latency:
  - Accept edge is cycle 0. busy=1 during cycles 1..WIDTH+1.
  - done=1 and the outputs update at cycle WIDTH+2 (34 for WIDTH=32). busy=0 in that cycle.
  - A new start is accepted in that same cycle (back-to-back operation).
- start while busy: ignored and not queued.
- Output hold: result/long_result/flags hold their last values until the next done. They do not change at accept.
- Multiply: shift-add on a 2*WIDTH accumulator.
  - MUL and UMUL treat operands as unsigned.
  - SMUL multiplies magnitudes; FINISH takes the two's-complement negation of the 2*WIDTH product if a[MSB]^b[MSB].
  - The most negative operand is handled correctly: its magnitude is 2^(WIDTH-1), held unsigned.
  - MUL: result = low WIDTH bits, long_result = 0.
- Divide: unsigned restoring division, one quotient bit per ITER cycle; result = quotient, long_result = remainder.
- Divide by zero: same fixed latency; result=0, long_result=a; no exception.
- Flags:
  - N = result[MSB] for MUL/DIV; long_result[MSB] for SMUL/UMUL.
  - Z = (result==0) for MUL/DIV; ({long_result,result}==0) for SMUL/UMUL.
  - C = 0, V = 0.

Decomposition:
- Shared package holds:
  - Op constants OP_MUL=3'b100, OP_SMUL=3'b101, OP_UMUL=3'b110, OP_DIV=3'b111 (also used by the decoder and the ALU).
  - State encodings S_IDLE, S_ITER, S_FINISH.
- Sub-module div_step:
  - Purely combinational single restoring-divide iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
  - Unit-testable on its own.
- The multiply datapath stays inline.

Test Plan:
- MUL a=7, b=6 -> done exactly 34 cycles after accept; result=0x0000002A, long_result=0, flags=4'b0000.
- SMUL a=0xFFFFFFFD (-3), b=5 -> long_result=0xFFFFFFFF, result=0xFFFFFFF1, flags N=1 Z=0; SMUL a=0x80000000, b=0x80000000 -> long_result=0x40000000, result=0.
- UMUL a=b=0xFFFFFFFF -> long_result=0xFFFFFFFE, result=0x00000001, N=1; UMUL a=0, b=123 -> Z=1.
- DIV a=100, b=7 -> result=14, long_result=2; DIV a=5, b=0 -> result=0, long_result=5, Z=1, same 34-cycle latency.
- Back-to-back and ignored requests:
  - start held high with new operands during busy -> ignored; only the first operation completes.
  - start with op=3'b010 in IDLE -> busy stays 0 and no done.
  - A start in the done cycle is accepted.
- Reset asserted at cycle 10 of a DIV -> next cycle: busy=0, done=0, all outputs 0, state IDLE; no done pulse follows; a fresh MUL then completes normally.
